// File: rtl/rr_arbiter8_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int unsigned NReq           = 8;
    localparam int unsigned IdW            = 3;
    localparam int unsigned MaxHoldDefault = 15;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StGap
    } state_e;

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority search: first set req bit at or above ptr, wrapping 7->0.
module rr_prio_pick
    import rr_arbiter8_pkg::*;
(
    input  logic [NReq-1:0] req,
    input  logic [IdW-1:0]  ptr,
    output logic            found,
    output logic [IdW-1:0]  idx
);

    logic [NReq-1:0] w_rot;
    logic [IdW-1:0]  w_off;

    // Bit i of w_rot is requester (ptr + i) mod 8.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NReq; i++) begin
            w_rot[i] = req[IdW'(i + int'(ptr))];
        end
    end

    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int i = NReq - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                found = 1'b1;
                w_off = IdW'(i);
            end
        end
    end

    assign idx = ptr + w_off;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with IDLE/BUSY/GAP handshake.
// Optional grant-hold timeout enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int unsigned N_REQ    = NReq,
    parameter int unsigned MAX_HOLD = MaxHoldDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IdW-1:0]   gnt_id,
    output logic             gnt_valid
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    if (N_REQ != NReq || MAX_HOLD == 0 || MAX_HOLD > 16) begin : g_bad_cfg
        $error("rr_arbiter8: unsupported N_REQ/MAX_HOLD");
    end

    state_e           r_state, w_state_d;
    logic [IdW-1:0]   r_ptr, w_ptr_d;
    logic [N_REQ-1:0] r_gnt, w_gnt_d;
    logic [IdW-1:0]   r_gnt_id, w_gnt_id_d;
    logic             r_gnt_valid, w_gnt_valid_d;
    logic             w_found;
    logic [IdW-1:0]   w_idx;
    logic             w_expire;

    rr_prio_pick u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_gnt       <= w_gnt_d;
            r_gnt_id    <= w_gnt_id_d;
            r_gnt_valid <= w_gnt_valid_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (w_found) w_state_d = StBusy;
            StBusy:  if (done || w_expire) w_state_d = StGap;
            StGap:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_ptr_d       = r_ptr;
        w_gnt_d       = r_gnt;
        w_gnt_id_d    = r_gnt_id;
        w_gnt_valid_d = r_gnt_valid;
        case (r_state)
            StIdle: begin
                if (w_found) begin
                    w_gnt_d       = N_REQ'(1) << w_idx;
                    w_gnt_id_d    = w_idx;
                    w_gnt_valid_d = 1'b1;
                    w_ptr_d       = w_idx + IdW'(1);
                end
            end
            StBusy: begin
                if (done || w_expire) begin
                    w_gnt_d       = '0;
                    w_gnt_id_d    = '0;
                    w_gnt_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [3:0] r_hold, w_hold_d;
    logic       r_timeout, w_timeout_d;

    assign w_expire = (r_state == StBusy) && (r_hold == 4'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_hold    <= w_hold_d;
            r_timeout <= w_timeout_d;
        end
    end

    // done has priority over the hold limit, so a coinciding done never pulses timeout.
    always_comb begin
        w_hold_d    = r_hold;
        w_timeout_d = 1'b0;
        if (r_state == StIdle && w_found) begin
            w_hold_d = '0;
        end else if (r_state == StBusy && !done) begin
            if (w_expire) begin
                w_timeout_d = 1'b1;
            end else begin
                w_hold_d = r_hold + 4'd1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 Parameter N_REQ, default 8, meaning number of requesters; only 8 is supported.
REQ-002 Parameter MAX_HOLD, default 15, meaning grant-hold limit in cycles; used only when RR_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 req  input  8  request vector; bit i is requester i; level-sensitive.
REQ-006 done  input  1  current grant holder releases the resource; single-cycle pulse.
REQ-007 gnt  output  8  one-hot grant vector, registered.
REQ-008 gnt_id  output  3  index of the granted requester, registered; valid only while gnt_valid is 1.
REQ-009 gnt_valid  output  1  a grant is active, registered.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released; exists only with RR_ARB_TIMEOUT_EN.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and GAP.
REQ-012 In IDLE with req != 0, the block SHALL select the first set req bit, searching upward from pointer ptr[2:0] with wrap 7->0.
REQ-013 On that edge it SHALL load gnt, gnt_id and gnt_valid=1 and enter BUSY, so gnt appears one cycle after req is sampled.
REQ-014 On each grant to index k, it SHALL update ptr to (k+1) mod 8 with 3-bit wrap.
REQ-015 In IDLE with req == 0, outputs and ptr SHALL hold at their idle values.
REQ-016 In BUSY, the grant SHALL hold regardless of req changes, including the holder dropping its req bit.
REQ-017 A done pulse in BUSY SHALL clear gnt, gnt_valid and gnt_id to 0 on the next edge and move the FSM to GAP.
REQ-018 GAP SHALL last exactly one cycle with no grant (turnaround) and then return to IDLE unconditionally.
REQ-019 done while in IDLE or GAP SHALL be ignored.
REQ-020 gnt SHALL always be one-hot or zero; gnt_valid SHALL be 1 exactly when gnt != 0, and gnt == (1 << gnt_id) whenever gnt_valid is 1.
REQ-021 Minimum spacing between successive grants SHALL be 3 cycles: grant, done, gap.
REQ-022 Fairness: a continuously asserted request SHALL be granted within 8 grant cycles.

Reset
REQ-023 Asserting rst_n low SHALL immediately force: FSM=IDLE, ptr=0, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold counter=0.
REQ-024 Reset asserted during BUSY SHALL drop the grant asynchronously with no done required.
REQ-025 On the first edge after rst_n deasserts, arbitration SHALL resume from ptr=0.

Configuration
REQ-026 With RR_ARB_TIMEOUT_EN defined, a 4-bit hold counter SHALL clear on grant and increment each BUSY cycle.
REQ-027 When the counter reaches MAX_HOLD-1 without done, the grant SHALL be released on the next edge, timeout SHALL pulse for one cycle, and the FSM SHALL enter GAP.
REQ-028 If done and the timeout condition coincide, done SHALL win and timeout SHALL stay 0.
REQ-029 Without RR_ARB_TIMEOUT_EN, the timeout port and hold counter SHALL be absent and a grant SHALL be held until done.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, BUSY, GAP), N_REQ=8, the ID width constant (3) and the default MAX_HOLD.
REQ-031 The search SHALL live in one combinational sub-module, rr_prio_pick: inputs req[7:0] and ptr[2:0]; outputs found and idx[2:0]; rotate, LSB-first scan, unrotate.

Verification
REQ-032 Reset, then req=8'b0000_0101 -> next cycle gnt=8'b0000_0001, gnt_id=0; after done and gap, gnt=8'b0000_0100, gnt_id=2.
REQ-033 req=8'hFF held, done pulsed one cycle after each grant -> gnt_id sequence 0,1,2,...,7,0 with 2 idle cycles between grants.
REQ-034 ptr=7 (after grant 6), req=8'b1000_0001 -> gnt_id=7; the next grant is gnt_id=0 (wrap).
REQ-035 Holder drops req mid-BUSY, then a done pulse in IDLE -> grant held until done in BUSY; the stray done causes no state change.
REQ-036 With RR_ARB_TIMEOUT_EN and MAX_HOLD=15, grant with no done -> gnt clears after 15 BUSY cycles with a one-cycle timeout pulse; done on that same cycle -> no timeout pulse.
REQ-037 rst_n low mid-BUSY -> gnt=0 immediately; after release, req=8'h80 -> gnt_id=7, with ptr starting from 0.
